// File: rtl/uart_rx.sv
// UART receiver: start, even parity, 8 data bits LSB first, stop.
// Samples each bit at its centre from a two-flop synchronised copy of the line.
//
// state  | meaning
// IDLE   | line idle, waiting for rxs low
// START  | confirm start bit at its centre; a high sample is a glitch
// PARITY | sample parity bit
// DATA   | sample 8 data bits, LSB first
// STOP   | sample stop bit, publish byte and status, pulse valid
// BRK    | stop bit was low; wait for line to return high
module uart_rx #(
  parameter int clksPerBit = 87
) (
  input  logic       i_clkRx,
  input  logic       i_rstnRx,
  input  logic       i_dataRx,
  output logic [7:0] o_bitsRx,
  output logic       o_validRx,
  output logic       o_parityErrorRx,
  output logic       o_frameErrorRx,
  output logic       o_busyRx
);

  localparam int CW = $clog2(clksPerBit) + 1;
  localparam logic [CW-1:0] HALF = CW'((clksPerBit - 1) / 2);
  localparam logic [CW-1:0] FULL = CW'(clksPerBit - 1);

  typedef enum logic [2:0] {IDLE, START, PARITY, DATA, STOP, BRK} state_t;

  state_t        r_state, w_state_nx;
  logic          r_sync1, r_rxs;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_idx, w_idx_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          r_par, w_par_nx;
  logic [7:0]    w_bits_nx;
  logic          w_valid_nx, w_perr_nx, w_ferr_nx;

  always_ff @(posedge i_clkRx or negedge i_rstnRx) begin
    if (!i_rstnRx) begin
      r_sync1         <= 1'b1;
      r_rxs           <= 1'b1;
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_shift         <= '0;
      r_par           <= 1'b0;
      o_bitsRx        <= '0;
      o_validRx       <= 1'b0;
      o_parityErrorRx <= 1'b0;
      o_frameErrorRx  <= 1'b0;
    end else begin
      r_sync1         <= i_dataRx;
      r_rxs           <= r_sync1;
      r_state         <= w_state_nx;
      r_cnt           <= w_cnt_nx;
      r_idx           <= w_idx_nx;
      r_shift         <= w_shift_nx;
      r_par           <= w_par_nx;
      o_bitsRx        <= w_bits_nx;
      o_validRx       <= w_valid_nx;
      o_parityErrorRx <= w_perr_nx;
      o_frameErrorRx  <= w_ferr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_par_nx   = r_par;
    w_bits_nx  = o_bitsRx;
    w_valid_nx = 1'b0;
    w_perr_nx  = o_parityErrorRx;
    w_ferr_nx  = o_frameErrorRx;
    case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        w_idx_nx = '0;
        if (!r_rxs) w_state_nx = START;
      end
      START: begin
        if (r_cnt < HALF) w_cnt_nx = r_cnt + 1'b1;
        else begin
          w_cnt_nx   = '0;
          w_state_nx = r_rxs ? IDLE : PARITY;
        end
      end
      PARITY: begin
        if (r_cnt < FULL) w_cnt_nx = r_cnt + 1'b1;
        else begin
          w_cnt_nx   = '0;
          w_par_nx   = r_rxs;
          w_state_nx = DATA;
        end
      end
      DATA: begin
        if (r_cnt < FULL) w_cnt_nx = r_cnt + 1'b1;
        else begin
          w_cnt_nx          = '0;
          w_shift_nx[r_idx] = r_rxs;
          if (r_idx == 3'd7) begin
            w_idx_nx   = '0;
            w_state_nx = STOP;
          end else begin
            w_idx_nx = r_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (r_cnt < FULL) w_cnt_nx = r_cnt + 1'b1;
        else begin
          // Errored frames are still reported; flags hold until the next frame.
          w_cnt_nx   = '0;
          w_bits_nx  = r_shift;
          w_perr_nx  = ^{r_shift, r_par};
          w_ferr_nx  = ~r_rxs;
          w_valid_nx = 1'b1;
          w_state_nx = r_rxs ? IDLE : BRK;
        end
      end
      BRK: begin
        if (r_rxs) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign o_busyRx = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random traffic,
// checked against a frame-level expectation queue.
module tb_uart_rx;

  localparam int CPB = 8;
  localparam int H   = (CPB - 1) / 2;
  // line fall -> rxs low seen (3 edges) -> start centre (H+1) -> stop centre (10 bits)
  localparam int LAT = 3 + H + 1 + 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic [7:0] bits;
  logic       valid, perr, ferr, busy;

  always #5 clk = ~clk;

  uart_rx #(.clksPerBit(CPB)) dut (
    .i_clkRx        (clk),
    .i_rstnRx       (rst_n),
    .i_dataRx       (line),
    .o_bitsRx       (bits),
    .o_validRx      (valid),
    .o_parityErrorRx(perr),
    .o_frameErrorRx (ferr),
    .o_busyRx       (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;
  int   busy_rise = -1;
  int   busy_fall = -1;
  logic prev_valid = 1'b0;
  logic prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame monitor: every valid pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (valid) begin
      pulses++;
      chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
      chk("valid_expected", {31'd0, (expq.size() > 0)}, 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rx_byte", {24'd0, bits}, {24'd0, e.data});
        chk("rx_parity_err", {31'd0, perr}, {31'd0, e.perr});
        chk("rx_frame_err", {31'd0, ferr}, {31'd0, e.ferr});
        chk("rx_valid_time", cyc, e.cyc);
      end
    end
    prev_valid = valid;
    if (busy && !prev_busy) busy_rise = cyc;
    if (!busy && prev_busy) busy_fall = cyc;
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; the line is left at the stop value for the caller.
  task automatic send_frame(input logic [7:0] d, input logic par_inv, input logic stop_val,
                            input int stop_len, output int t0);
    exp_t x;
    logic par;
    par    = (^d) ^ par_inv;
    t0     = cyc;
    x.data = d;
    x.perr = (par != (^d));
    x.ferr = (stop_val == 1'b0);
    x.cyc  = t0 + LAT;
    expq.push_back(x);
    line = 1'b0;
    repeat (CPB) tick();
    line = par;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      repeat (CPB) tick();
    end
    line = stop_val;
    repeat (stop_len) tick();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && (expq.size() != 0 || busy); i++) tick();
    chk("drain_timeout", {31'd0, (expq.size() == 0 && !busy)}, 32'd1);
  endtask

  initial begin
    int t, t2, p;
    logic [7:0] d;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_bits", {24'd0, bits}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_perr", {31'd0, perr}, 32'd0);
    chk("reset_ferr", {31'd0, ferr}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Single clean frame with busy window timing
    send_frame(8'hA5, 1'b0, 1'b1, CPB, t);
    wait_done(200);
    chk("a5_pulses", pulses, 32'd1);
    chk("a5_busy_rise", busy_rise, t + 3);
    chk("a5_busy_fall", busy_fall, t + LAT);
    chk("a5_bits_hold", {24'd0, bits}, 32'h0000_00A5);

    // Back-to-back frames
    send_frame(8'h01, 1'b0, 1'b1, CPB, t);
    send_frame(8'hFE, 1'b0, 1'b1, CPB, t);
    wait_done(200);
    chk("b2b_pulses", pulses, 32'd3);
    chk("b2b_last_byte", {24'd0, bits}, 32'h0000_00FE);

    // Inverted parity bit
    send_frame(8'h3C, 1'b1, 1'b1, CPB, t);
    wait_done(200);
    chk("par_err_flag", {31'd0, perr}, 32'd1);
    chk("par_err_ferr", {31'd0, ferr}, 32'd0);

    // Low stop bit followed by 30 low clocks, then a clean frame
    send_frame(8'h55, 1'b0, 1'b0, CPB, t);
    repeat (30) tick();
    chk("brk_pulses", pulses, 32'd5);
    chk("brk_busy", {31'd0, busy}, 32'd1);
    chk("brk_no_restart", busy_rise, t + 3);
    chk("brk_ferr", {31'd0, ferr}, 32'd1);
    line = 1'b1;
    repeat (6) tick();
    chk("brk_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b0, 1'b1, CPB, t);
    wait_done(200);
    chk("after_brk_pulses", pulses, 32'd6);
    chk("after_brk_ferr", {31'd0, ferr}, 32'd0);

    // Two-clock glitch: START aborts, nothing reported
    p    = pulses;
    t    = cyc;
    line = 1'b0;
    repeat (2) tick();
    line = 1'b1;
    repeat (12) tick();
    chk("glitch_rise", busy_rise, t + 3);
    chk("glitch_fall", busy_fall, t + 3 + H + 1);
    chk("glitch_no_pulse", pulses, p);
    chk("glitch_bits", {24'd0, bits}, 32'h0000_0081);
    chk("glitch_perr", {31'd0, perr}, 32'd0);
    chk("glitch_ferr", {31'd0, ferr}, 32'd0);

    // Reset in the middle of DATA for 0x77
    p    = pulses;
    line = 1'b0;
    repeat (CPB) tick();
    line = ^8'h77;
    repeat (CPB) tick();
    d = 8'h77;
    for (int i = 0; i < 3; i++) begin
      line = d[i];
      repeat (CPB) tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bits", {24'd0, bits}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_perr", {31'd0, perr}, 32'd0);
    chk("mid_rst_ferr", {31'd0, ferr}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    line = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("mid_rst_no_pulse", pulses, p);
    send_frame(8'h12, 1'b0, 1'b1, CPB, t);
    wait_done(200);
    chk("post_rst_pulses", pulses, p + 1);
    chk("post_rst_byte", {24'd0, bits}, 32'h0000_0012);

    // Random traffic: random bytes, parity faults, stretched stops, short gaps
    p = pulses;
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, ($urandom_range(0, 3) == 0), 1'b1, CPB + $urandom_range(0, 1), t2);
      line = 1'b1;
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_done(400);
    chk("rand_pulses", pulses, p + 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
